sum_sub_nbit_ncc: RTL
=====================

Name: sum_sub_nbit_ncc

Overview:
Parametrised digit-serial two's-complement adder/subtractor for sequential garbled-circuit netlists.
- Consumes N-bit operands W bits per clock, LSB digit first, over CC = N/W cycles.
- Carries the running carry in a register between digits.
- Generalises the 1-bit-per-cycle serial adder with: digit width, add/subtract mode, word framing (start/last), stall support, and registered carry-out/signed-overflow flags.

Parameters:
- N, 32: total operand width in bits; must be a multiple of W (elaboration error otherwise).
- W, 1: digit width, i.e. bits processed per cycle; 1 <= W <= N.
- CC, N/W: derived localparam, digits per word; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  qualifies the current beat as digit 0 of a new word; sampled only when in_valid=1.
- sub  in  1  mode (0 add, 1 subtract), sampled on a start beat only.
- in_valid  in  1  a digit is present on g_input/e_input this cycle.
- g_input  in  W  garbler operand digit A[k*W +: W].
- e_input  in  W  evaluator operand digit B[k*W +: W].
- o  out  W  result digit: A+B or A-B, bits [k*W +: W].
- out_valid  out  1  o is meaningful; equals in_valid & (busy | start).
- last  out  1  current beat is digit CC-1; combinational.
- done  out  1  one-cycle pulse, the cycle after the last digit is accepted.
- carry_out  out  1  registered carry out of bit N-1; for subtract, 1 means no borrow.
- overflow  out  1  registered signed overflow: carry into bit N-1 XOR carry out of bit N-1.

Behaviour:
- Reset: synchronous, active-high. All outputs and registers are 0, state IDLE, digit counter 0, carry 0, mode 0. Reset wins over every other input in the same cycle, and aborts any word in flight without asserting done.
- States: IDLE and RUN.
  - IDLE: ignores beats unless start & in_valid.
  - RUN: accepts one digit per in_valid cycle.
- Effective carry-in and operand for a digit:
  - cin = (start beat) ? sub_in : carry_q.
  - Operand B is e_input XOR {W{mode}}, where mode is sub on the start beat and mode_q afterwards.
- Result path: o = g_input + B' + cin, W-bit ripple, combinational (latency 0 from inputs).
- Register updates on each accepted digit:
  - carry_q <= carry out of the digit's MSB.
  - cnt <= cnt+1.
  - mode_q is latched on the start beat.
- CC=1 case: the start beat is also the last beat.
- Last beat (cnt==CC-1, or CC==1 on a start beat):
  - Next cycle: carry_out <= digit carry out; overflow <= carry into digit MSB XOR digit carry out; done <= 1.
  - State returns to IDLE; cnt <= 0.
- Flag hold: carry_out and overflow hold their values until the next word's last beat or reset.
- Stall: in_valid=0 holds cnt, carry_q, mode_q and state; out_valid=0.
- Start while in RUN: the current word is abandoned with no done. The beat becomes digit 0 of a new word (cin and mode are re-sampled from sub).
- Non-start beat in IDLE: ignored; o is still driven combinationally but out_valid=0.
- Back-to-back words: start on the cycle after the last beat is legal. done for word n and digit 0 of word n+1 then appear in the same cycle.
- No wrap: cnt never exceeds CC-1.

Decomposition:
- Package sum_sub_pkg holds:
  - state enum {IDLE, RUN};
  - a function clog2 for counter width, CNT_W = max(1, clog2(CC)).
- Sub-module digit_adder_w (parameter W), purely combinational:
  - ports a, b, cin, s, cout, c_msb_in;
  - carry chain built from XOR/XNOR/AND gates only, to stay garbled-circuit friendly (cheap XOR, minimised non-XOR gates).
- The top level contains the FSM, counter, mode/carry registers and flag registers.

Test Plan:
- N=32, W=1, add: A=0x0000FFFF, B=0x00000001 over 32 beats -> o bits assemble to 0x00010000, done on beat 33, carry_out=0, overflow=0.
- N=32, W=8, sub: A=5, B=7 over 4 beats -> result 0xFFFFFFFE, carry_out=0 (borrow), overflow=0.
- N=32, W=8, add: A=0x7FFFFFFF, B=1 -> result 0x80000000, overflow=1, carry_out=0. Then A=0xFFFFFFFF, B=1 -> result 0, carry_out=1, overflow=0.
- N=16, W=4, add with in_valid low for 3 cycles between digits 1 and 2: A=0x1234, B=0x0FFF -> result 0x2233, done exactly once, 1 cycle after the 4th accepted digit.
- Mid-word start after 2 digits of a word, followed by a full word 0x0001+0x0001 (N=16, W=4) -> result 0x0002, exactly one done pulse. Separately, rst asserted mid-word -> all outputs 0 next cycle, no done.
- N=8, W=8 (CC=1): back-to-back start beats 0x80-0x01 then 0x01+0x01 -> o=0x7F then 0x02; done high on both following cycles; first overflow=1, second overflow=0.

Source files
------------

// File: rtl/sum_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_e    : word-framing FSM states.
//   clog2      : ceiling log2 for sizing the digit counter.
//   cnt_width  : digit counter width, never narrower than one bit.
package sum_sub_pkg;

   typedef enum logic [0:0] {IDLE, RUN} state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v == 0) ? 0 : v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned cc);
      return (cc <= 1) ? 1 : clog2(cc);
   endfunction

endpackage

// File: rtl/sum_sub_nbit_ncc_if.sv
// Digit stream bundle for sum_sub_nbit_ncc.
//   start/sub/in_valid/g_input/e_input : beat from the producer.
//   o/out_valid/last                    : combinational result digit and framing.
//   done/carry_out/overflow             : registered end-of-word status.
// master drives the beats, slave is the arithmetic block.
interface sum_sub_nbit_ncc_if #(
   parameter int unsigned W = 1
);
   logic         start;
   logic         sub;
   logic         in_valid;
   logic [W-1:0] g_input;
   logic [W-1:0] e_input;
   logic [W-1:0] o;
   logic         out_valid;
   logic         last;
   logic         done;
   logic         carry_out;
   logic         overflow;

   modport master (
      output start, sub, in_valid, g_input, e_input,
      input  o, out_valid, last, done, carry_out, overflow
   );

   modport slave (
      input  start, sub, in_valid, g_input, e_input,
      output o, out_valid, last, done, carry_out, overflow
   );
endinterface

// File: rtl/digit_adder_w.sv
// W-bit combinational ripple adder for one digit.
//   a, b     : operand digits (b already conditionally inverted by the caller).
//   cin      : carry into bit 0.
//   s        : sum digit.
//   cout     : carry out of bit W-1.
//   c_msb_in : carry into bit W-1 (needed for signed overflow).
// Each carry uses c ^ ((a ^ c) & (b ^ c)): one AND per bit, the rest XOR,
// which keeps the non-free gate count minimal in a garbled netlist.
module digit_adder_w #(
   parameter int unsigned W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         c_msb_in
);
   logic [W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = c[i] ^ ((a[i] ^ c[i]) & (b[i] ^ c[i]));
   end

   assign cout     = c[W];
   assign c_msb_in = c[W-1];
endmodule

// File: rtl/sum_sub_nbit_ncc.sv
// Digit-serial two's-complement adder/subtractor, W bits per beat, LSB digit
// first, CC = N/W beats per word.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : slave side of sum_sub_nbit_ncc_if (beats in, digits and flags out).
// The result digit is combinational from the current beat; carry, mode, digit
// count and the end-of-word flags are registered.
module sum_sub_nbit_ncc
   import sum_sub_pkg::*;
#(
   parameter int unsigned N = 32,
   parameter int unsigned W = 1
) (
   input logic               clk,
   input logic               rst,
   sum_sub_nbit_ncc_if.slave bus
);
   localparam int unsigned CC    = N / W;
   localparam int unsigned CNT_W = cnt_width(CC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CC - 1);

   if (W == 0 || W > N || (N % W) != 0) begin : g_bad_params
      $error("sum_sub_nbit_ncc: N must be a non-zero multiple of W");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             mode_q, mode_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;

   logic             start_beat, accept, last_beat;
   logic             mode_eff, cin;
   logic [W-1:0]     b_eff, sum;
   logic             dig_cout, dig_c_msb;

   // A start beat opens a new word in any state, abandoning one in flight.
   assign start_beat = bus.in_valid & bus.start;
   assign accept     = bus.in_valid & (bus.start | (state_q == RUN));
   assign mode_eff   = start_beat ? bus.sub : mode_q;
   assign cin        = start_beat ? bus.sub : carry_q;
   assign b_eff      = bus.e_input ^ {W{mode_eff}};
   assign last_beat  = accept & (start_beat ? (CC == 1) : (cnt_q == CNT_LAST));

   digit_adder_w #(
      .W(W)
   ) u_digit (
      .a        (bus.g_input),
      .b        (b_eff),
      .cin      (cin),
      .s        (sum),
      .cout     (dig_cout),
      .c_msb_in (dig_c_msb)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      mode_d      = mode_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      done_d      = 1'b0;
      if (accept) begin
         carry_d = dig_cout;
         mode_d  = mode_eff;
         if (last_beat) begin
            state_d     = IDLE;
            cnt_d       = '0;
            done_d      = 1'b1;
            carry_out_d = dig_cout;
            overflow_d  = dig_c_msb ^ dig_cout;
         end else begin
            state_d = RUN;
            cnt_d   = start_beat ? CNT_W'(1) : cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         mode_q      <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         mode_q      <= mode_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
      end
   end

   assign bus.o         = sum;
   assign bus.out_valid = accept;
   assign bus.last      = last_beat;
   assign bus.done      = done_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
endmodule
